// File: rtl/dl_pkg.sv
// dl_pkg: shared types for the dl_* blocks
package dl_pkg;
  typedef enum logic {ST_EMPTY, ST_HOLD} pending_drain_state_t;
endpackage

// File: rtl/dl_prio_enc.sv
// dl_prio_enc: lowest-set-bit encoder, idx=0 when nothing is set
module dl_prio_enc #(
  parameter int NUM_BITS = 8,
  localparam int IDX_W = $clog2(NUM_BITS)
) (
  input  logic [NUM_BITS-1:0] in,
  output logic [IDX_W-1:0]    idx,
  output logic                found
);
  always_comb begin
    idx = '0;
    for (int i = NUM_BITS - 1; i >= 0; i--) idx = in[i] ? IDX_W'(i) : idx;
  end
  assign found = |in;
endmodule

// File: rtl/dl_pending_drain.sv
// dl_pending_drain: sticky OR-merged pending set drained lowest index first over valid/ready
module dl_pending_drain
  import dl_pkg::*;
#(
  parameter int NUM_BITS = 8,
  localparam int IDX_W = $clog2(NUM_BITS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_BITS-1:0] set_vec,
  input  logic                clr_all,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [IDX_W-1:0]    out_idx,
  output logic [NUM_BITS-1:0] pending
);
  pending_drain_state_t state, state_nxt;
  logic [NUM_BITS-1:0] pending_nxt, load_mask;
  logic [IDX_W-1:0] enc_idx;
  logic found, transfer, load;
  dl_prio_enc #(.NUM_BITS(NUM_BITS)) u_enc (.in(pending), .idx(enc_idx), .found(found));
  assign out_valid = state == ST_HOLD;
  // set_vec is OR'd last so a same-cycle set survives both flush and its own load
  always_comb begin
    transfer = out_valid & out_ready;
    load = (~out_valid | transfer) & found & ~clr_all;
    load_mask = load ? (NUM_BITS'(1) << enc_idx) : '0;
    pending_nxt = (pending & ~load_mask & {NUM_BITS{~clr_all}}) | set_vec;
    state_nxt = clr_all ? ST_EMPTY : load ? ST_HOLD : transfer ? ST_EMPTY : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_EMPTY;
      pending <= '0;
      out_idx <= '0;
    end else begin
      state <= state_nxt;
      pending <= pending_nxt;
      if (load) out_idx <= enc_idx;
    end
  end
endmodule

// File: tb/tb_dl_pending_drain.sv
// tb_dl_pending_drain: scoreboard bench with a set-based reference model
module tb_dl_pending_drain;
  logic clk = 0, rst = 0;
  logic [7:0] set_vec = 0, pending;
  logic clr_all = 0, out_ready = 0, out_valid;
  logic [2:0] out_idx;
  logic [1:0] s2_set = 0, s2_pend;
  logic s2_valid;
  logic [0:0] s2_idx;
  logic [63:0] s64_set = 0, s64_pend;
  logic s64_valid;
  logic [5:0] s64_idx;
  int errors = 0, checks = 0;
  bit go = 0, done2 = 0, done64 = 0;
  logic [7:0] m_pend = 0;
  bit m_hv = 0;
  int m_held = 0;
  int exp_q[$], got_q[$];

  always #5 clk = ~clk;

  dl_pending_drain #(.NUM_BITS(8)) dut (.clk(clk), .rst(rst), .set_vec(set_vec), .clr_all(clr_all),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx), .pending(pending));
  dl_pending_drain #(.NUM_BITS(2)) u2 (.clk(clk), .rst(rst), .set_vec(s2_set), .clr_all(1'b0),
    .out_valid(s2_valid), .out_ready(1'b1), .out_idx(s2_idx), .pending(s2_pend));
  dl_pending_drain #(.NUM_BITS(64)) u64 (.clk(clk), .rst(rst), .set_vec(s64_set), .clr_all(1'b0),
    .out_valid(s64_valid), .out_ready(1'b1), .out_idx(s64_idx), .pending(s64_pend));

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  // one clock of stimulus; the model advances at the same rising edge as the DUT
  task automatic step(input logic [7:0] s, input logic c, input logic r);
    logic [7:0] np;
    bit nhv;
    int nh, lo;
    @(negedge clk);
    set_vec = s; clr_all = c; out_ready = r;
    if (m_hv && r) exp_q.push_back(m_held);
    np = m_pend; nhv = m_hv; nh = m_held;
    if (c) begin
      np = 0; nhv = 0;
    end else if (!m_hv || r) begin
      lo = lowest(m_pend);
      nhv = lo >= 0;
      if (lo >= 0) begin
        nh = lo;
        np[lo] = 1'b0;
      end
    end
    np |= s;
    @(posedge clk);
    m_pend = np; m_hv = nhv; m_held = nh;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; set_vec = 8'hFF; clr_all = 0; out_ready = 0;
    m_pend = 0; m_hv = 0; m_held = 0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 0; set_vec = 0;
  endtask

  task automatic drain();
    for (int n = 0; n < 20 && (m_hv || m_pend != 0); n++) step(0, 0, 1);
    step(0, 0, 0);
  endtask

  task automatic chk_seq(input string name, input int e[$]);
    chk({name, "_len"}, got_q.size(), e.size());
    for (int i = 0; i < e.size() && i < got_q.size(); i++) chk(name, got_q[i], e[i]);
    got_q.delete();
  endtask

  always begin
    @(negedge clk);
    #1;
    chk("valid", out_valid, m_hv);
    chk("pending", pending, m_pend);
    if (m_hv || rst) chk("held_idx", out_idx, rst ? 0 : m_held);
    if (out_valid && out_ready) begin
      got_q.push_back(out_idx);
      if (exp_q.size() == 0) chk("xfer_unexpected", out_idx, 8'hEE);
      else chk("xfer_idx", out_idx, exp_q.pop_front());
    end
  end

  initial begin
    int n;
    wait (go);
    @(negedge clk); s2_set = '1;
    @(negedge clk); s2_set = 0;
    n = 0;
    repeat (8) begin
      @(negedge clk); #1;
      if (s2_valid) begin chk("sw2_idx", s2_idx, n); n++; end
    end
    chk("sw2_count", n, 2);
    chk("sw2_idle", {s2_valid, s2_pend}, 0);
    done2 = 1;
  end

  initial begin
    int n;
    wait (go);
    @(negedge clk); s64_set = '1;
    @(negedge clk); s64_set = 0;
    n = 0;
    repeat (70) begin
      @(negedge clk); #1;
      if (s64_valid) begin chk("sw64_idx", s64_idx, n); n++; end
    end
    chk("sw64_count", n, 64);
    chk("sw64_idle", {s64_valid, s64_pend}, 0);
    done64 = 1;
  end

  initial begin
    do_reset();
    go = 1;
    wait (done2 && done64);
    got_q.delete();
    step(8'hA5, 0, 1);
    repeat (6) step(0, 0, 1);
    chk_seq("burst", '{0, 2, 5, 7});
    step(8'h12, 0, 0);
    repeat (5) step(0, 0, 0);
    repeat (4) step(0, 0, 1);
    chk_seq("backpressure", '{1, 4});
    step(8'h08, 0, 0);
    step(0, 0, 0);
    step(8'h09, 0, 0);
    repeat (5) step(0, 0, 1);
    chk_seq("rearm", '{3, 0, 3});
    step(8'hF4, 0, 0);
    step(0, 0, 0);
    step(8'h01, 1, 0);
    step(0, 0, 0);
    chk("flush_held", {m_hv, 8'(m_held)}, {1'b1, 8'd0});
    drain();
    got_q.delete();
    for (int i = 0; i < 400; i++)
      step(8'($urandom & $urandom), $urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0);
    drain();
    step(8'h3C, 0, 0);
    step(8'h81, 0, 0);
    do_reset();
    step(0, 0, 1);
    step(8'h40, 0, 1);
    drain();
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dl_pending_drain.md
Name: dl_pending_drain

Overview:
- Sequential counterpart to the bitwise-OR set operation: event vectors are OR-merged into a sticky pending register.
- The block drains that register one index at a time over a valid/ready output, lowest index first.
- Each bit is cleared as it is handed off.
- Intended for interrupt/exception pending sets, scoreboard release and similar "many setters, one consumer" paths in the core.

Parameters:
- NUM_BITS, 8, width of the pending vector; legal range 2..64.
- IDX_W, $clog2(NUM_BITS), width of the emitted index; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- set_vec  input  NUM_BITS  bits to OR into pending this cycle.
- clr_all  input  1  synchronous flush of pending and of the output register.
- out_valid  output  1  out_idx holds a drained index.
- out_ready  input  1  consumer accepts out_idx this cycle.
- out_idx  output  IDX_W  index of the drained bit.
- pending  output  NUM_BITS  current pending register, not including the bit held in the output register.

Behaviour:
- Reset (async assert, sync release): pending=0, out_valid=0, out_idx=0, state=ST_EMPTY.
- Handshake: a transfer occurs on a cycle with out_valid & out_ready.
- Output stability: once out_valid=1, out_idx must not change and out_valid must not drop until the transfer. The only exception is clr_all.
- States:
  - ST_EMPTY: out_valid=0.
  - ST_HOLD: out_valid=1.
- Load condition: load = (state==ST_EMPTY | transfer) & (pending != 0) & ~clr_all.
- On load:
  - out_idx <= lowest set index of the current pending register (not set_vec).
  - That bit is removed from pending.
  - State goes to, or stays in, ST_HOLD.
- On transfer with pending==0 (and no clr_all): state goes to ST_EMPTY, out_valid=0 next cycle.
- Pending next-state: pending_nxt = ((pending & ~load_mask) & {NUM_BITS{~clr_all}}) | set_vec.
  - load_mask is one-hot of the loaded index, or 0 if no load.
  - set_vec has highest priority: a bit set in the same cycle as clr_all or as its own load stays pending.
- clr_all: next cycle, state=ST_EMPTY, out_valid=0, out_idx unchanged; pending = set_vec of that cycle.
- Latency: set_vec bit at cycle N -> visible on pending at N+1 -> out_valid at N+2, if the output register is free.
- Throughput: one index per cycle while out_ready is held high and pending is nonzero.
- Re-arm: a bit that is set again while its index sits in the output register becomes pending again and is delivered a second time. No deduplication against the output register.
- Setting an already-pending bit has no effect (idempotent OR).
- Ordering: strictly lowest-index-first at each load. A newly set low index can overtake older high indices.
- out_ready while out_valid=0 is ignored.
- Reset mid-operation: immediate return to reset values. The in-flight index is lost.

Decomposition:
- Package dl_pkg gains the state enum pending_drain_state_t {ST_EMPTY, ST_HOLD}.
- Sub-module dl_prio_enc #(NUM_BITS): combinational lowest-set-bit encoder.
  - Inputs: in [NUM_BITS].
  - Outputs: idx [IDX_W], found (= |in).
  - idx=0 when found=0.
  - Reusable by other blocks.

Test Plan:
- Reset: assert rst with set_vec=8'hFF -> pending=0, out_valid=0, out_idx=0 throughout reset; on release with set_vec=0, nothing emitted.
- Burst drain: set_vec=8'b1010_0101 for one cycle, out_ready=1 -> out_valid from cycle+2, out_idx sequence 0,2,5,7 on consecutive cycles, then out_valid=0 and pending=0.
- Backpressure: set_vec=8'h12, out_ready=0 for 5 cycles -> out_idx=1 held stable with out_valid=1 and pending=8'h10; raise out_ready -> 1 then 4 transferred.
- Re-arm and overtake: while idx 3 is held with out_ready=0, set_vec=8'h09 -> pending=8'h09; release ready -> sequence 3,0,3.
- Flush priority: pending=8'hF0, out_valid=1 with idx 2, then clr_all=1 with set_vec=8'h01 in the same cycle -> next cycle out_valid=0, pending=8'h01; following cycle out_valid=1, out_idx=0.
- Parameter sweep: NUM_BITS=2 and 64, set all bits -> indices 0..NUM_BITS-1 in order with no gaps, then out_valid=0.
